// File: rtl/counter_monitor_pkg.sv
// Shared types and defaults for the counter_monitor receive-side checker.
// Optional sticky-error feature in the top is enabled by COUNTER_MONITOR_STICKY_EN.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_LOCK_COUNT = 2;
  localparam int DEFAULT_ERR_WIDTH  = 8;
  localparam int MATCH_WIDTH        = 4;

  // Carry-out of the observed counter is high exactly when its low 'width' bits are all ones.
  function automatic logic expected_carry(input logic [31:0] value, input int width);
    logic result;
    result = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (b < width) result = result & value[b];
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Lock-and-check monitor for a free-running up-counter stream (count plus carry-out).
// Define COUNTER_MONITOR_STICKY_EN to add the clr_sticky input and err_sticky output.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT,
  parameter int ERR_WIDTH  = DEFAULT_ERR_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     I,
  input  logic                 CIN,
`ifdef COUNTER_MONITOR_STICKY_EN
  input  logic                 clr_sticky,
  output logic                 err_sticky,
`endif
  output logic                 locked,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [MATCH_WIDTH-1:0] LOCK_LIMIT = MATCH_WIDTH'(LOCK_COUNT);

  state_t                 state;
  logic [WIDTH-1:0]       prev;
  logic [MATCH_WIDTH-1:0] match_cnt;
  logic [MATCH_WIDTH-1:0] match_next;
  logic                   good;
  logic                   err_hit;

  assign good       = (I == WIDTH'(prev + 1'b1)) && (CIN == expected_carry(32'(I), WIDTH));
  assign match_next = match_cnt + MATCH_WIDTH'(1);
  assign err_hit    = EN && (state == LOCKED) && !good;

  // The first sample after HUNT only seeds prev; lock needs LOCK_COUNT good steps after it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= HUNT;
      prev      <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (EN) begin
        prev <= I;
        case (state)
          HUNT: begin
            state     <= CHECK;
            match_cnt <= '0;
          end
          CHECK: begin
            if (good) begin
              if (match_next == LOCK_LIMIT) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_next;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!good) begin
              state     <= CHECK;
              locked    <= 1'b0;
              err       <= 1'b1;
              match_cnt <= '0;
            end
          end
          default: begin
            state     <= HUNT;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W (ERR_WIDTH)
  ) u_err_count (
    .clk   (CLK),
    .rst_n (RESETN),
    .inc   (err_hit),
    .q     (err_count)
  );

`ifdef COUNTER_MONITOR_STICKY_EN
  // Setting has priority so an error coinciding with a clear is never lost.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      err_sticky <= 1'b0;
    end else if (err_hit) begin
      err_sticky <= 1'b1;
    end else if (clr_sticky) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Receive-side checker for the free-running up-counter stream (count value plus carry-out).
- Samples the count each enabled cycle and locks onto the +1 sequence, including wrap-around.
- Checks that the carry-out matches the all-ones value.
- Reports lock status, one-cycle error pulses and a saturating error count.
- Sits on the board-level side of the counter output, e.g. between the counter and the J1 debug pins.

Parameters:
- WIDTH, 4, width of the observed count value.
- LOCK_COUNT, 2, number of consecutive good transitions needed to enter LOCKED (1..15).
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  reset, asynchronous, active-low.
- EN  input  1  sample-valid; a sample is taken only on cycles with EN=1.
- I  input  WIDTH  observed count value.
- CIN  input  1  observed carry-out, qualified by EN.
- locked  output  1  monitor is in the LOCKED state.
- err  output  1  one-cycle pulse on a sequence error while LOCKED.
- err_count  output  ERR_WIDTH  saturating count of errors.

Behaviour:
- Reset (asynchronous assert on RESETN=0, synchronous deassert):
  - state=HUNT, prev=0, match_cnt=0.
  - locked=0, err=0, err_count=0.
  - Reset mid-operation discards lock immediately, with no err pulse.
- Good sample, in CHECK and LOCKED only: good = (I == prev+1 mod 2^WIDTH) AND (CIN == &I).
  - CIN rule: carry is asserted in the same sample in which I is all-ones.
- prev <= I on every EN=1 cycle, in every state.
- EN=0: state, prev, match_cnt and err_count hold; err=0.
- HUNT:
  - First EN=1 sample is accepted unconditionally.
  - Transition to CHECK with match_cnt=0.
- CHECK:
  - good: match_cnt+1; when the incremented value reaches LOCK_COUNT, go to LOCKED and reset match_cnt to 0.
  - bad: match_cnt=0, stay in CHECK. No err pulse; errors are counted only while LOCKED.
- LOCKED:
  - good: stay in LOCKED.
  - bad: err=1 for exactly the next cycle, err_count+1 (saturates at all-ones, never wraps), state to CHECK, match_cnt=0.
- Latency: all outputs are registered.
  - err, locked and err_count update on the clock edge that samples I; visible one cycle after the sample is presented.
- Wrap-around: prev=all-ones followed by I=0 with CIN=0 is good. The sample I=all-ones itself must carry CIN=1.
- A frozen counter (I repeats) is bad.
- Back-to-back errors: each LOCKED bad sample must first relock (LOCK_COUNT good transitions) before a further error pulse. At most one err pulse per lock episode.
- locked is high exactly while state==LOCKED.

Optional Feature:
- Macro: COUNTER_MONITOR_STICKY_EN.
- When defined, adds:
  - input clr_sticky (1 bit);
  - output err_sticky (1 bit, reset 0).
- err_sticky sets on any cycle err is set and stays set until a cycle with clr_sticky=1.
- Simultaneous clr_sticky and error: set wins.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package counter_monitor_pkg:
  - state enum: HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2;
  - default WIDTH, LOCK_COUNT and ERR_WIDTH constants;
  - helper function computing expected carry (&value).
- Sub-module sat_counter (parameter W; inc, q, saturating, async active-low reset) holds err_count.
- Everything else is one FSM process plus prev/match registers.

Test Plan:
- Reset, then EN=1 with I=0,1,2,3 and CIN=&I → locked=1 one cycle after the I=2 sample; err=0 throughout; err_count=0.
- Locked run 13,14,15 (CIN=1),0,1 → locked stays 1, no err; wrap accepted.
- Locked, then I=5 after prev=3 → err=1 for one cycle, err_count=1, locked=0; then 6,7 → relock.
- Locked at I=15 with CIN=0 → err pulse, err_count increments; locked=1 with I=14, CIN=1 → err.
- Drive 300 isolated errors with relock between them (ERR_WIDTH=8) → err_count saturates at 255. EN=0 gaps mid-sequence → no state change. RESETN low mid-LOCKED → all outputs 0 immediately.
- With COUNTER_MONITOR_STICKY_EN: error → err_sticky=1 held; clr_sticky pulse → 0; clr_sticky coincident with error → stays 1.
